// File: rtl/mips_debug_controller_pkg.sv
// ---------------------------------------------------------------------------
// mips_debug_controller_pkg
// Shared definitions for the MIPS debug controller: host command opcodes,
// stop-reason codes and run-control state encodings.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_debug_controller_pkg;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_RUN       = 3'd1,
    CMD_STEP_N    = 3'd2,
    CMD_SET_BP    = 3'd3,
    CMD_CLR_BP    = 3'd4,
    CMD_STOP      = 3'd5,
    CMD_DUMP_REGS = 3'd6,
    CMD_DUMP_MEM  = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    REASON_STOP  = 2'd0,
    REASON_COUNT = 2'd1,
    REASON_BP    = 2'd2,
    REASON_HALT  = 2'd3
  } reason_e;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_RUN         = 3'd1,
    ST_STEP        = 3'd2,
    ST_DUMP_SETTLE = 3'd3,
    ST_DUMP_OUT    = 3'd4
  } state_e;

endpackage

// File: rtl/mips_debug_controller_dump_sequencer.sv
// ---------------------------------------------------------------------------
// mips_debug_controller_dump_sequencer
// Walks the word index of a register-file or data-memory dump, drives the
// read index/address into the pipeline, captures the read data and holds it
// on a valid/ready stream until the sink takes it.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, start_mem  begin a dump (start_mem=1: memory, 0: registers)
//   settle            controller is in the settle phase: capture this cycle
//   dump_ready        sink accepts the current word
//   pc, register_data, data_memory   pipeline read data
//   debug_reg_num, debug_address     pipeline read index/address
//   dump_valid, dump_data, dump_last output word stream
// ---------------------------------------------------------------------------
module mips_debug_controller_dump_sequencer #(
  parameter int NB              = 32,
  parameter int NB_REG_ADDR     = 5,
  parameter int N_REGS          = 32,
  parameter int TAM_DATA_MEMORY = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   start_mem,
  input  logic                   settle,
  input  logic                   dump_ready,
  input  logic [NB-1:0]          pc,
  input  logic [NB-1:0]          register_data,
  input  logic [NB-1:0]          data_memory,
  output logic [NB_REG_ADDR-1:0] debug_reg_num,
  output logic [NB-1:0]          debug_address,
  output logic                   dump_valid,
  output logic [NB-1:0]          dump_data,
  output logic                   dump_last
);

  // Register dumps emit the PC ahead of the registers, hence N_REGS+1 words.
  localparam int MAX_WORDS = (N_REGS + 1 > TAM_DATA_MEMORY) ? N_REGS + 1 : TAM_DATA_MEMORY;
  localparam int IDX_W     = $clog2(MAX_WORDS + 1);

  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] last_idx;
  logic             mem_mode;
  logic [NB-1:0]    word;

  // Index 0 of a register dump is the PC, so register k lives at index k+1.
  assign last_idx      = mem_mode ? IDX_W'(TAM_DATA_MEMORY - 1) : IDX_W'(N_REGS);
  assign debug_reg_num = (mem_mode || index == '0) ? '0 : NB_REG_ADDR'(index - 1'b1);
  assign debug_address = mem_mode ? NB'({index, 2'b00}) : '0;
  assign word          = mem_mode ? data_memory : ((index == '0) ? pc : register_data);

  // Capture on settle, then hold until the handshake advances the index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index      <= '0;
      mem_mode   <= 1'b0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
      dump_data  <= '0;
    end else if (start) begin
      index      <= '0;
      mem_mode   <= start_mem;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
    end else if (settle) begin
      dump_data  <= word;
      dump_valid <= 1'b1;
      dump_last  <= (index == last_idx);
    end else if (dump_valid && dump_ready) begin
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
      index      <= index + 1'b1;
    end
  end

endmodule

// File: rtl/mips_debug_controller.sv
// ---------------------------------------------------------------------------
// mips_debug_controller
// Run-control and state-readout engine between the host command link and
// the MIPS pipeline: continuous run, step-N, PC breakpoint, HALT detection,
// and register/data-memory dumps over a valid/ready stream.
// Ports:
//   i_clk, i_reset_n                     clock, async active-low reset
//   i_cmd_valid/i_cmd/i_cmd_arg/o_cmd_ready  host command handshake
//   o_cmd_err                            pulse: command consumed but ignored
//   i_mips_pc, i_mips_halt               pipeline status
//   o_step                               pipeline advance enable
//   o_debug_reg_num, o_debug_address     pipeline read index/address
//   i_mips_register_data, i_mips_data_memory  pipeline read data
//   o_dump_valid/o_dump_data/o_dump_last/i_dump_ready  dump stream
//   o_busy, o_stop_reason, o_cycle_count status
// ---------------------------------------------------------------------------
module mips_debug_controller
  import mips_debug_controller_pkg::*;
#(
  parameter int NB              = 32,
  parameter int NB_REG_ADDR     = 5,
  parameter int N_REGS          = 32,
  parameter int TAM_DATA_MEMORY = 16,
  parameter int NB_CNT          = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_cmd_valid,
  input  logic [2:0]             i_cmd,
  input  logic [NB-1:0]          i_cmd_arg,
  output logic                   o_cmd_ready,
  output logic                   o_cmd_err,
  input  logic [NB-1:0]          i_mips_pc,
  input  logic                   i_mips_halt,
  output logic                   o_step,
  output logic [NB_REG_ADDR-1:0] o_debug_reg_num,
  output logic [NB-1:0]          o_debug_address,
  input  logic [NB-1:0]          i_mips_register_data,
  input  logic [NB-1:0]          i_mips_data_memory,
  output logic                   o_dump_valid,
  output logic [NB-1:0]          o_dump_data,
  output logic                   o_dump_last,
  input  logic                   i_dump_ready,
  output logic                   o_busy,
  output logic [1:0]             o_stop_reason,
  output logic [NB_CNT-1:0]      o_cycle_count
);

  state_e            state;
  cmd_e              cmd;
  logic [NB-1:0]     bp_addr;
  logic              bp_en;
  logic              skip;
  logic [NB_CNT-1:0] step_cnt;
  logic [NB_CNT-1:0] arg_cnt;
  logic              running;
  logic              cmd_fire;
  logic              halt_stop;
  logic              bp_stop;
  logic              step_done;
  logic              dump_start;

  assign cmd        = cmd_e'(i_cmd);
  assign arg_cnt    = i_cmd_arg[NB_CNT-1:0];
  assign running    = (state == ST_RUN) || (state == ST_STEP);
  assign o_cmd_ready = running || (state == ST_IDLE);
  assign o_busy     = (state != ST_IDLE);
  assign cmd_fire   = i_cmd_valid && o_cmd_ready;

  // skip masks the breakpoint for the first step after a resume so the
  // pipeline can leave the PC it stopped on.
  assign halt_stop  = running && i_mips_halt;
  assign bp_stop    = running && bp_en && (i_mips_pc == bp_addr) && !skip;
  assign o_step     = running && !halt_stop && !bp_stop;
  assign step_done  = (state == ST_STEP) && o_step && (step_cnt == NB_CNT'(1));
  assign dump_start = (state == ST_IDLE) && cmd_fire &&
                      ((cmd == CMD_DUMP_REGS) || (cmd == CMD_DUMP_MEM));

  // Run-control FSM with breakpoint, step counter and saturating cycle count.
  // Stop conditions outrank the count and the STOP command when they coincide.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      bp_addr       <= '0;
      bp_en         <= 1'b0;
      skip          <= 1'b0;
      step_cnt      <= '0;
      o_cycle_count <= '0;
      o_stop_reason <= REASON_STOP;
      o_cmd_err     <= 1'b0;
    end else begin
      o_cmd_err <= 1'b0;
      if (o_step) begin
        skip <= 1'b0;
        if (o_cycle_count != '1) o_cycle_count <= o_cycle_count + 1'b1;
        if (state == ST_STEP) step_cnt <= step_cnt - 1'b1;
      end
      if (running && cmd_fire && (cmd != CMD_STOP)) o_cmd_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            case (cmd)
              CMD_RUN: begin
                state <= ST_RUN;
                skip  <= 1'b1;
              end
              CMD_STEP_N: begin
                state    <= ST_STEP;
                skip     <= 1'b1;
                step_cnt <= (arg_cnt == '0) ? NB_CNT'(1) : arg_cnt;
              end
              CMD_SET_BP: begin
                bp_addr <= i_cmd_arg;
                bp_en   <= 1'b1;
              end
              CMD_CLR_BP:    bp_en <= 1'b0;
              CMD_DUMP_REGS: state <= ST_DUMP_SETTLE;
              CMD_DUMP_MEM:  state <= ST_DUMP_SETTLE;
              default: ;
            endcase
          end
        end
        ST_RUN, ST_STEP: begin
          if (halt_stop) begin
            state         <= ST_IDLE;
            o_stop_reason <= REASON_HALT;
          end else if (bp_stop) begin
            state         <= ST_IDLE;
            o_stop_reason <= REASON_BP;
          end else if (step_done) begin
            state         <= ST_IDLE;
            o_stop_reason <= REASON_COUNT;
          end else if (cmd_fire && (cmd == CMD_STOP)) begin
            state         <= ST_IDLE;
            o_stop_reason <= REASON_STOP;
          end
        end
        ST_DUMP_SETTLE: state <= ST_DUMP_OUT;
        ST_DUMP_OUT: begin
          if (i_dump_ready) state <= o_dump_last ? ST_IDLE : ST_DUMP_SETTLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mips_debug_controller_dump_sequencer #(
    .NB              (NB),
    .NB_REG_ADDR     (NB_REG_ADDR),
    .N_REGS          (N_REGS),
    .TAM_DATA_MEMORY (TAM_DATA_MEMORY)
  ) dump_seq (
    .clk           (i_clk),
    .rst_n         (i_reset_n),
    .start         (dump_start),
    .start_mem     (cmd == CMD_DUMP_MEM),
    .settle        (state == ST_DUMP_SETTLE),
    .dump_ready    (i_dump_ready),
    .pc            (i_mips_pc),
    .register_data (i_mips_register_data),
    .data_memory   (i_mips_data_memory),
    .debug_reg_num (o_debug_reg_num),
    .debug_address (o_debug_address),
    .dump_valid    (o_dump_valid),
    .dump_data     (o_dump_data),
    .dump_last     (o_dump_last)
  );

endmodule

// File: tb/tb_mips_debug_controller.sv
// ---------------------------------------------------------------------------
// tb_mips_debug_controller
// Self-checking bench for mips_debug_controller. A tiny pipeline model
// advances the PC by 4 on every stepped cycle; register k reads as k and
// memory word k reads as 0x100+k. Expected step PCs and dump words are
// queued when stimulus is applied and popped by a negedge monitor.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_debug_controller;
  import mips_debug_controller_pkg::*;

  localparam int NB          = 32;
  localparam int NB_REG_ADDR = 5;
  localparam int N_REGS      = 32;
  localparam int TAM         = 16;
  localparam int NB_CNT      = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   cmd_valid;
  logic [2:0]             cmd;
  logic [NB-1:0]          cmd_arg;
  logic                   cmd_ready;
  logic                   cmd_err;
  logic [NB-1:0]          mips_pc;
  logic                   mips_halt;
  logic                   step;
  logic [NB_REG_ADDR-1:0] debug_reg_num;
  logic [NB-1:0]          debug_address;
  logic [NB-1:0]          register_data;
  logic [NB-1:0]          data_memory;
  logic                   dump_valid;
  logic [NB-1:0]          dump_data;
  logic                   dump_last;
  logic                   dump_ready;
  logic                   busy;
  logic [1:0]             stop_reason;
  logic [NB_CNT-1:0]      cycle_count;

  int checks;
  int errors;
  logic step_check_en;
  logic pc_hold;
  logic s_step, s_ready, s_err, s_busy;
  logic hold_pending;
  logic [NB-1:0] hold_data;
  logic [NB-1:0] step_q[$];
  logic [NB:0]   dump_q[$];

  always #5 clk = ~clk;

  // Pipeline read model
  assign register_data = NB'(debug_reg_num);
  assign data_memory   = 32'h100 + (debug_address >> 2);

  mips_debug_controller #(
    .NB(NB), .NB_REG_ADDR(NB_REG_ADDR), .N_REGS(N_REGS),
    .TAM_DATA_MEMORY(TAM), .NB_CNT(NB_CNT)
  ) dut (
    .i_clk                (clk),
    .i_reset_n            (rst_n),
    .i_cmd_valid          (cmd_valid),
    .i_cmd                (cmd),
    .i_cmd_arg            (cmd_arg),
    .o_cmd_ready          (cmd_ready),
    .o_cmd_err            (cmd_err),
    .i_mips_pc            (mips_pc),
    .i_mips_halt          (mips_halt),
    .o_step               (step),
    .o_debug_reg_num      (debug_reg_num),
    .o_debug_address      (debug_address),
    .i_mips_register_data (register_data),
    .i_mips_data_memory   (data_memory),
    .o_dump_valid         (dump_valid),
    .o_dump_data          (dump_data),
    .o_dump_last          (dump_last),
    .i_dump_ready         (dump_ready),
    .o_busy               (busy),
    .o_stop_reason        (stop_reason),
    .o_cycle_count        (cycle_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Scoreboard monitor: steps and dump handshakes are popped against queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (step && step_check_en) begin
        if (step_q.size() == 0) checkOutput("step_extra", step, 0);
        else checkOutput("step_pc", mips_pc, step_q.pop_front());
      end
      if (hold_pending && dump_valid) checkOutput("dump_hold", dump_data, hold_data);
      if (dump_valid && dump_ready) begin
        if (dump_q.size() == 0) checkOutput("dump_extra", dump_valid, 0);
        else begin
          logic [NB:0] e;
          e = dump_q.pop_front();
          checkOutput("dump_data", dump_data, e[NB-1:0]);
          checkOutput("dump_last", dump_last, e[NB]);
        end
      end
    end
    hold_pending = dump_valid && !dump_ready;
    hold_data    = dump_data;
  end

  // One clock: sample outputs at negedge, then advance the PC model after posedge
  task automatic tick();
    @(negedge clk);
    s_step  = step;
    s_ready = cmd_ready;
    s_err   = cmd_err;
    s_busy  = busy;
    @(posedge clk);
    #1;
    if (s_step && !pc_hold) mips_pc = mips_pc + 32'd4;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [NB-1:0] arg);
    cmd_valid = 1'b1;
    cmd       = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
    cmd       = CMD_NOP;
    cmd_arg   = '0;
  endtask

  task automatic runUntilIdle(input string tag, input int limit, input bit toggle);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      if (toggle) dump_ready = ~dump_ready;
      tick();
      if (!s_busy) done = 1'b1;
    end
    checkOutput(tag, done, 1);
  endtask

  task automatic resetDut();
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd        = CMD_NOP;
    cmd_arg    = '0;
    mips_halt  = 1'b0;
    dump_ready = 1'b0;
    pc_hold    = 1'b0;
    mips_pc    = '0;
    step_q.delete();
    dump_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    step_check_en = 1'b1;
    hold_pending  = 1'b0;
    hold_data     = '0;

    // Reset state
    resetDut();
    checkOutput("rst_step", step, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_err", cmd_err, 0);
    checkOutput("rst_count", cycle_count, 0);
    checkOutput("rst_reason", stop_reason, 0);
    checkOutput("rst_dvalid", dump_valid, 0);
    checkOutput("rst_dlast", dump_last, 0);
    checkOutput("rst_ddata", dump_data, 0);
    checkOutput("rst_regnum", debug_reg_num, 0);
    checkOutput("rst_addr", debug_address, 0);

    // STEP_N 3
    step_q.push_back(32'h0);
    step_q.push_back(32'h4);
    step_q.push_back(32'h8);
    applyStimulus(CMD_STEP_N, 32'd3);
    runUntilIdle("stepn_done", 50, 1'b0);
    checkOutput("stepn_count", cycle_count, 3);
    checkOutput("stepn_reason", stop_reason, 1);
    checkOutput("stepn_q", step_q.size(), 0);

    // Breakpoint at 0x10, then resume past it and end with HALT
    resetDut();
    applyStimulus(CMD_SET_BP, 32'h10);
    for (int k = 0; k < 4; k++) step_q.push_back(NB'(4 * k));
    applyStimulus(CMD_RUN, '0);
    runUntilIdle("bp_done", 50, 1'b0);
    checkOutput("bp_reason", stop_reason, 2);
    checkOutput("bp_count", cycle_count, 4);
    checkOutput("bp_q", step_q.size(), 0);
    for (int k = 0; k < 6; k++) step_q.push_back(NB'(32'h10 + 4 * k));
    applyStimulus(CMD_RUN, '0);
    repeat (6) tick();
    checkOutput("resume_busy", s_busy, 1);
    mips_halt = 1'b1;
    tick();
    checkOutput("resume_halt_step", s_step, 0);
    mips_halt = 1'b0;
    tick();
    checkOutput("resume_idle", s_busy, 0);
    checkOutput("resume_reason", stop_reason, 3);
    checkOutput("resume_count", cycle_count, 10);
    checkOutput("resume_q", step_q.size(), 0);

    // HALT on the 5th RUN cycle
    resetDut();
    for (int k = 0; k < 4; k++) step_q.push_back(NB'(4 * k));
    applyStimulus(CMD_RUN, '0);
    repeat (4) tick();
    mips_halt = 1'b1;
    tick();
    checkOutput("halt_step", s_step, 0);
    mips_halt = 1'b0;
    tick();
    checkOutput("halt_idle", s_busy, 0);
    checkOutput("halt_reason", stop_reason, 3);
    checkOutput("halt_count", cycle_count, 4);
    checkOutput("halt_q", step_q.size(), 0);

    // Ignored command while running, STOP, and STOP coinciding with HALT
    step_check_en = 1'b0;
    applyStimulus(CMD_RUN, '0);
    tick();
    applyStimulus(CMD_SET_BP, 32'h200);
    tick();
    checkOutput("run_err", s_err, 1);
    checkOutput("run_err_busy", s_busy, 1);
    applyStimulus(CMD_STOP, '0);
    tick();
    checkOutput("stop_idle", s_busy, 0);
    checkOutput("stop_reason", stop_reason, 0);
    checkOutput("stop_no_err", s_err, 0);
    applyStimulus(CMD_RUN, '0);
    tick();
    mips_halt = 1'b1;
    applyStimulus(CMD_STOP, '0);
    checkOutput("stophalt_step", s_step, 0);
    mips_halt = 1'b0;
    tick();
    checkOutput("stophalt_idle", s_busy, 0);
    checkOutput("stophalt_reason", stop_reason, 3);

    // STEP_N with count 0 behaves as a single step
    step_check_en = 1'b1;
    resetDut();
    step_q.push_back(32'h0);
    applyStimulus(CMD_STEP_N, 32'd0);
    runUntilIdle("step0_done", 50, 1'b0);
    checkOutput("step0_count", cycle_count, 1);
    checkOutput("step0_reason", stop_reason, 1);
    checkOutput("step0_q", step_q.size(), 0);

    // Memory dump with ready toggling every cycle
    resetDut();
    for (int k = 0; k < TAM; k++) dump_q.push_back({(k == TAM - 1), NB'(32'h100 + k)});
    applyStimulus(CMD_DUMP_MEM, '0);
    runUntilIdle("mem_done", 200, 1'b1);
    checkOutput("mem_q", dump_q.size(), 0);
    checkOutput("mem_valid_after", dump_valid, 0);

    // Register dump; a STEP_N offered meanwhile must not be accepted
    dump_ready = 1'b0;
    mips_pc    = 32'h24;
    dump_q.push_back({1'b0, 32'h24});
    for (int k = 0; k < N_REGS; k++) dump_q.push_back({(k == N_REGS - 1), NB'(k)});
    applyStimulus(CMD_DUMP_REGS, '0);
    cmd_valid = 1'b1;
    cmd       = CMD_STEP_N;
    cmd_arg   = 32'd5;
    repeat (3) begin
      tick();
      checkOutput("dump_cmd_ready", s_ready, 0);
    end
    cmd_valid  = 1'b0;
    cmd        = CMD_NOP;
    cmd_arg    = '0;
    dump_ready = 1'b1;
    runUntilIdle("regs_done", 200, 1'b0);
    checkOutput("regs_q", dump_q.size(), 0);
    checkOutput("regs_count", cycle_count, 0);
    checkOutput("regs_no_step", step_q.size(), 0);

    // Reset mid-RUN clears outputs and the breakpoint
    resetDut();
    step_check_en = 1'b0;
    applyStimulus(CMD_SET_BP, 32'h10);
    applyStimulus(CMD_RUN, '0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("rstrun_step", step, 0);
    checkOutput("rstrun_busy", busy, 0);
    checkOutput("rstrun_count", cycle_count, 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    pc_hold = 1'b1;
    mips_pc = 32'h10;
    applyStimulus(CMD_RUN, '0);
    repeat (4) begin
      tick();
      checkOutput("bp_cleared_step", s_step, 1);
    end
    pc_hold = 1'b0;
    applyStimulus(CMD_STOP, '0);
    tick();

    // Reset mid-dump
    dump_ready = 1'b0;
    applyStimulus(CMD_DUMP_MEM, '0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("rstdump_valid", dump_valid, 0);
    checkOutput("rstdump_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step_check_en = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_debug_controller.md
Name: mips_debug_controller

Overview:
- Run-control and state-readout engine for the MIPS pipeline; sits between the host command link (UART/debug front end) and the pipeline's step/debug ports.
- Generalises single-bit stepping into modes: continuous run, step-N, PC breakpoint, HALT detection, plus sequenced register-file and data-memory dumps over a valid/ready stream.

Parameters:
- NB, 32, data/PC width.
- NB_REG_ADDR, 5, debug register index width.
- N_REGS, 32, registers emitted by a register dump.
- TAM_DATA_MEMORY, 16, data-memory words emitted by a memory dump (byte addresses 0, 4, ...).
- NB_CNT, 16, step counter and cycle counter width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_cmd_valid  in  1  command present.
- i_cmd  in  3  opcode: 0 NOP, 1 RUN, 2 STEP_N, 3 SET_BP, 4 CLR_BP, 5 STOP, 6 DUMP_REGS, 7 DUMP_MEM.
- i_cmd_arg  in  NB  STEP_N count (low NB_CNT bits) or breakpoint PC.
- o_cmd_ready  out  1  command accepted when valid&&ready.
- o_cmd_err  out  1  one-cycle pulse: command consumed but ignored.
- i_mips_pc  in  NB  current pipeline PC.
- i_mips_halt  in  1  pipeline has retired HALT.
- o_step  out  1  pipeline advance enable.
- o_debug_reg_num  out  NB_REG_ADDR  register-file read index.
- o_debug_address  out  NB  data-memory read byte address.
- i_mips_register_data  in  NB  combinational read of o_debug_reg_num.
- i_mips_data_memory  in  NB  combinational read of o_debug_address.
- o_dump_valid  out  1  dump word valid.
- o_dump_data  out  NB  dump word.
- o_dump_last  out  1  final word of dump.
- i_dump_ready  in  1  sink accepts word.
- o_busy  out  1  state != IDLE.
- o_stop_reason  out  2  0 STOP cmd, 1 count done, 2 breakpoint, 3 HALT.
- o_cycle_count  out  NB_CNT  cycles with o_step=1; saturates at all-ones.

Behaviour:
- Reset (async, any state): state IDLE, o_step=0, o_dump_valid=0, o_dump_last=0, o_dump_data=0, o_debug_reg_num=0, o_debug_address=0, breakpoint disabled (address 0), step counter 0, o_cycle_count=0, o_stop_reason=0, o_cmd_err=0.
- States: IDLE, RUN, STEP, DUMP_SETTLE, DUMP_OUT.
- o_cmd_ready=1 in IDLE, RUN, STEP; 0 in both dump states.
- IDLE: RUN->RUN; STEP_N->STEP, counter=arg, arg 0 treated as 1; SET_BP latches arg and enables the breakpoint; CLR_BP disables it; both stay IDLE. DUMP_REGS/DUMP_MEM->DUMP_SETTLE with index 0. STOP and NOP in IDLE: no effect, no error.
- RUN/STEP: STOP->IDLE with reason 0. Any other valid command is consumed, ignored, and pulses o_cmd_err.
- o_step is Mealy: 1 only in RUN/STEP when no stop condition holds this cycle.
- Stop conditions: i_mips_halt (reason 3, highest priority), or bp enabled && i_mips_pc==bp && !skip (reason 2). On a stop condition: o_step=0 that cycle, next state IDLE.
- skip flag: set on entering RUN/STEP; cleared after the first o_step=1 cycle. This lets resume-from-breakpoint advance past the breakpoint PC.
- STEP: each o_step cycle decrements the counter. When the step taken has counter==1, next state IDLE, reason 1.
- Simultaneous STOP command and stop condition: the condition's reason wins; o_step=0.
- Dumps:
  - DUMP_REGS word sequence: PC first, then registers 0..N_REGS-1 (N_REGS+1 words).
  - DUMP_MEM word sequence: addresses 0, 4, ..., 4*(TAM_DATA_MEMORY-1).
  - DUMP_SETTLE drives the index onto o_debug_reg_num/o_debug_address for one cycle, then registers the read data into o_dump_data with o_dump_valid=1 and moves to DUMP_OUT.
  - DUMP_OUT holds o_dump_data stable until i_dump_ready. On the handshake, the next index goes to DUMP_SETTLE; after the last word, go to IDLE. o_dump_last=1 with the final word only.
  - o_step=0 throughout any dump.
- o_cycle_count increments when o_step=1 and holds at 2^NB_CNT-1.

Decomposition:
- Shared package/header (debug_constants.vh): command opcodes, stop-reason codes, state encodings.
- One sub-module, debug_dump_sequencer: index counter, settle/out handshake, last-word flag. The top module holds the run-control FSM, breakpoint and counters.

Test Plan:
- Reset, then STEP_N arg=3 with PC advancing by 4 from 0 -> o_step high exactly 3 cycles; o_cycle_count=3; o_stop_reason=1; o_busy low after.
- SET_BP 0x10, then RUN -> o_step high at PC 0,4,8,12 and low at PC 0x10; reason 2. A second RUN -> one step past 0x10, then free run.
- RUN with i_mips_halt asserted on the 5th cycle -> o_step=0 that cycle; reason 3; o_cycle_count=4.
- DUMP_MEM with i_dump_ready toggling every other cycle, memory word k=0x100+k -> 16 words 0x100..0x10F in order; o_dump_last only on 0x10F; data held while ready=0.
- DUMP_REGS with reg k=k, PC=0x24 -> 33 words: 0x24, 0, 1, ..., 31; last on 31. STEP_N issued during the dump sees o_cmd_ready=0.
- Assert i_reset_n low mid-RUN and mid-dump -> o_step, o_dump_valid, o_busy drop immediately; breakpoint cleared; o_cycle_count=0.
